// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package mem_port_arbiter_pkg;

    localparam int unsigned REQ_ADDR_W = 64;
    localparam int unsigned DATA_W     = 64;
    localparam int unsigned STRB_W     = 8;
    localparam int unsigned SIZE_W     = 3;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } arb_state_t;

    typedef enum logic {
        OWN_INST,
        OWN_DATA
    } arb_owner_t;

    // Instruction fetches are always a single 32-bit word.
    localparam logic [SIZE_W-1:0] MSIZE_W4 = 3'd2;

    typedef struct packed {
        logic [REQ_ADDR_W-1:0] addr;
        logic [SIZE_W-1:0]     size;
        logic [STRB_W-1:0]     strobe;
        logic [DATA_W-1:0]     wdata;
    } mem_req_t;

endpackage

// File: rtl/arb_select.sv
// Combinational tie-break between the fetch and data requesters.
module arb_select
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned RR_MODE = 0
) (
    input  logic       inst_valid_i,
    input  logic       data_valid_i,
    input  arb_owner_t last_owner_i,
    output logic       gnt_valid_o,
    output arb_owner_t gnt_owner_o
);

    // A lone requester always wins; on a tie, data wins unless round-robin
    // hands the port to whoever did not own it last.
    always_comb begin
        gnt_valid_o = inst_valid_i | data_valid_i;
        gnt_owner_o = OWN_INST;
        if (inst_valid_i && data_valid_i) begin
            if ((RR_MODE == 0) || (last_owner_i == OWN_INST)) begin
                gnt_owner_o = OWN_DATA;
            end
        end else if (data_valid_i) begin
            gnt_owner_o = OWN_DATA;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one downstream memory port between fetch and data requesters,
// one outstanding transaction at a time.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned RR_MODE = 0,
    parameter int unsigned ADDR_W  = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_valid,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ready,
    output logic              i_rvalid,
    output logic [31:0]       i_rdata,
    input  logic              d_valid,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [2:0]        d_size,
    input  logic [7:0]        d_strobe,
    input  logic [63:0]       d_wdata,
    output logic              d_ready,
    output logic              d_rvalid,
    output logic [63:0]       d_rdata,
    output logic              m_valid,
    output logic [ADDR_W-1:0] m_addr,
    output logic [2:0]        m_size,
    output logic [7:0]        m_strobe,
    output logic [63:0]       m_wdata,
    input  logic              m_ready,
    input  logic              m_rvalid,
    input  logic [63:0]       m_rdata
);

    arb_state_t state_q, state_d;
    arb_owner_t owner_q, owner_d;
    arb_owner_t last_owner_q, last_owner_d;
    mem_req_t   req_q, req_d;
    logic       sel_hi_q, sel_hi_d;
    logic       gnt_valid;
    arb_owner_t gnt_owner;
    logic       rsp_fire;

    arb_select #(
        .RR_MODE(RR_MODE)
    ) u_arb_select (
        .inst_valid_i(i_valid),
        .data_valid_i(d_valid),
        .last_owner_i(last_owner_q),
        .gnt_valid_o (gnt_valid),
        .gnt_owner_o (gnt_owner)
    );

    // State, ownership and request register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            owner_q      <= OWN_INST;
            last_owner_q <= OWN_INST;
            req_q        <= '0;
            sel_hi_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            req_q        <= req_d;
            sel_hi_q     <= sel_hi_d;
        end
    end

    // Grant in IDLE, hold the request until accepted, then wait for the response.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        req_d        = req_q;
        sel_hi_d     = sel_hi_q;
        i_ready      = 1'b0;
        d_ready      = 1'b0;
        rsp_fire     = 1'b0;

        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    state_d      = ISSUE;
                    owner_d      = gnt_owner;
                    last_owner_d = gnt_owner;
                    if (gnt_owner == OWN_INST) begin
                        i_ready      = 1'b1;
                        req_d.addr   = REQ_ADDR_W'(i_addr);
                        req_d.size   = MSIZE_W4;
                        req_d.strobe = '0;
                        req_d.wdata  = '0;
                        sel_hi_d     = i_addr[2];
                    end else begin
                        d_ready      = 1'b1;
                        req_d.addr   = REQ_ADDR_W'(d_addr);
                        req_d.size   = d_size;
                        req_d.strobe = d_strobe;
                        req_d.wdata  = d_wdata;
                    end
                end
            end
            ISSUE: begin
                if (m_ready) begin
                    if (m_rvalid) begin
                        rsp_fire = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        state_d  = WAIT;
                    end
                end
            end
            WAIT: begin
                if (m_rvalid) begin
                    rsp_fire = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Nothing is granted or delivered while reset is asserted.
        if (reset) begin
            i_ready  = 1'b0;
            d_ready  = 1'b0;
            rsp_fire = 1'b0;
        end
    end

    // Downstream request driven straight from the registered payload.
    assign m_valid  = (state_q == ISSUE);
    assign m_addr   = req_q.addr[ADDR_W-1:0];
    assign m_size   = req_q.size;
    assign m_strobe = req_q.strobe;
    assign m_wdata  = req_q.wdata;

    // Response routed to the owner; fetches pick the word selected by addr[2].
    assign i_rvalid = rsp_fire && (owner_q == OWN_INST);
    assign d_rvalid = rsp_fire && (owner_q == OWN_DATA);
    assign i_rdata  = sel_hi_q ? m_rdata[63:32] : m_rdata[31:0];
    assign d_rdata  = m_rdata;

endmodule
